// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the N-channel stream multiplexer.
//   mux_mode_e : selection mode (MODE_FIXED uses the sel port, MODE_RR uses round-robin)
//   CNT_W      : width of the optional per-channel transfer counters
//   wrap_inc   : channel index increment with wrap-around modulo n
package stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

  localparam int CNT_W = 16;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/stream_mux_if.sv
// Handshake bundle for stream_mux_n.
//   in_data/in_valid/in_ready : NCH input streams, channel i at in_data[i*WIDTH +: WIDTH]
//   mode/sel                  : selection control
//   out_data/out_valid/out_ch : registered output stream and source channel index
//   out_ready                 : downstream ready
// Modports: slave = the multiplexer, master = whatever drives the inputs and sinks the output.
interface stream_mux_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  localparam int SELW = $clog2(NCH);

  logic [NCH*WIDTH-1:0]         in_data;
  logic [NCH-1:0]               in_valid;
  logic [NCH-1:0]               in_ready;
  stream_mux_pkg::mux_mode_e    mode;
  logic [SELW-1:0]              sel;
  logic [WIDTH-1:0]             out_data;
  logic                         out_valid;
  logic [SELW-1:0]              out_ch;
  logic                         out_ready;

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        : request vector
//   en         : when low, no grant is issued
//   last_grant : index of the previous winner; search starts at last_grant+1
//   grant      : one-hot grant, zero when en is low or nothing is requested
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]         req,
  input  logic                   en,
  input  logic [$clog2(NCH)-1:0] last_grant,
  output logic [NCH-1:0]         grant
);
  localparam int SELW = $clog2(NCH);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = wrap_inc(32'(last_grant), NCH);
    // Walk NCH positions starting just after the last winner; first hit wins.
    for (int i = 0; i < NCH; i++) begin
      if (!found && req[SELW'(idx)]) begin
        grant[SELW'(idx)] = 1'b1;
        found             = 1'b1;
      end
      idx = wrap_inc(idx, NCH);
    end
    if (!en) grant = '0;
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel streaming multiplexer with a registered output stage.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : stream_mux_if.slave (inputs, selection control, registered output)
//   grant_cnt  : only with STREAM_MUX_CNT_EN defined; saturating per-channel transfer
//                counters, channel i at [i*CNT_W +: CNT_W]
// Selection is either the sel port (MODE_FIXED) or round-robin (MODE_RR). The
// round-robin pointer only advances on an RR transfer, so fixed-mode traffic
// leaves the RR order untouched.
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_mux_if.slave     bus
`ifdef STREAM_MUX_CNT_EN
  ,
  output logic [NCH*CNT_W-1:0] grant_cnt
`endif
);
  localparam int SELW = $clog2(NCH);

  logic [NCH-1:0]   grant_fix;
  logic [NCH-1:0]   grant_rr;
  logic [NCH-1:0]   grant;
  logic [NCH-1:0]   rdy;
  logic             load_en;
  logic             xfer;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;

  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic [SELW-1:0]  out_ch_q;
  logic [SELW-1:0]  last_grant;

  // Output register is empty or being drained this cycle.
  assign load_en = !out_valid_q || bus.out_ready;

  // Out-of-range sel matches no channel and yields no grant.
  always_comb begin
    grant_fix = '0;
    for (int i = 0; i < NCH; i++) begin
      if (32'(bus.sel) == i) grant_fix[i] = bus.in_valid[i];
    end
  end

  rr_arbiter #(.NCH(NCH)) u_rr_arbiter (
    .req        (bus.in_valid),
    .en         (bus.mode == MODE_RR),
    .last_grant (last_grant),
    .grant      (grant_rr)
  );

  assign grant        = (bus.mode == MODE_RR) ? grant_rr : grant_fix;
  assign rdy          = grant & {NCH{load_en}};
  assign bus.in_ready = rdy;
  // A grant always implies in_valid, so any ready bit is a transfer.
  assign xfer         = |(rdy & bus.in_valid);

  always_comb begin
    grant_idx  = '0;
    grant_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        grant_idx  = SELW'(i);
        grant_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      last_grant  <= SELW'(NCH - 1);
    end else if (xfer) begin
      out_data_q  <= grant_data;
      out_ch_q    <= grant_idx;
      out_valid_q <= 1'b1;
      if (bus.mode == MODE_RR) last_grant <= grant_idx;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;

`ifdef STREAM_MUX_CNT_EN
  logic [NCH-1:0][CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (rdy[i] && bus.in_valid[i] && (cnt_q[i] != {CNT_W{1'b1}}))
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_stream_mux_n.sv
module tb_stream_mux_n;
  import stream_mux_pkg::*;

  logic clk;
  logic rst_n;

  stream_mux_if #(.WIDTH(8), .NCH(4)) bus ();

`ifdef STREAM_MUX_CNT_EN
  logic [4*CNT_W-1:0] grant_cnt;
`endif

  stream_mux_n #(.WIDTH(8), .NCH(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef STREAM_MUX_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int ch, input logic [7:0] v);
    bus.in_data[ch*8 +: 8] = v;
  endtask

  // Reference model: output-register occupancy, RR pointer, scoreboard of
  // expected beats {ch[1:0], data[7:0]}. Evaluated on the falling edge, when
  // inputs are stable; its next-state values are what the DUT shows after
  // the following rising edge.
  logic [9:0] sbq[$];
  logic       m_ov   = 1'b0;
  int         m_last = 3;

  always @(negedge clk) begin
    logic [3:0] g;
    logic [3:0] rdy_exp;
    logic [9:0] e;
    logic       le;
    int         c;
    int         win;
    if (!rst_n) begin
      m_ov   = 1'b0;
      m_last = 3;
      sbq.delete();
    end else begin
      chk("out_valid", bus.out_valid, m_ov);
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 0, 1);
        end else begin
          e = sbq.pop_front();
          chk("sb_out_data", bus.out_data, e[7:0]);
          chk("sb_out_ch", bus.out_ch, e[9:8]);
        end
      end
      g   = 4'b0000;
      win = -1;
      if (bus.mode == MODE_RR) begin
        for (int k = 1; k <= 4; k++) begin
          c = (m_last + k) % 4;
          if (win < 0 && bus.in_valid[c]) win = c;
        end
      end else if (bus.in_valid[bus.sel]) begin
        win = int'(bus.sel);
      end
      if (win >= 0) g[win] = 1'b1;
      le      = !m_ov || bus.out_ready;
      rdy_exp = le ? g : 4'b0000;
      chk("in_ready", bus.in_ready, rdy_exp);
      if (rdy_exp != 4'b0000) begin
        sbq.push_back({2'(win), bus.in_data[win*8 +: 8]});
        m_ov = 1'b1;
        if (bus.mode == MODE_RR) m_last = win;
      end else if (bus.out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 4'b0000;
    bus.in_data   = '0;
    bus.mode      = MODE_FIXED;
    bus.sel       = 2'd0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_ch", bus.out_ch, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Round-robin fairness, all channels valid
    @(posedge clk); #1;
    bus.mode     = MODE_RR;
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_data(i, 8'(8'h10 + i));
    @(negedge clk); chk("rr_first_ready", bus.in_ready, 4'b0001);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); chk("rr_seq_all", bus.out_ch, k % 4);
    end

    // Round-robin with channels 1 and 3 only
    @(posedge clk); #1 bus.in_valid = 4'b1010;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("rr_seq_1010", bus.out_ch, (k % 2 == 0) ? 1 : 3);
    end

    // Fixed select
    @(posedge clk); #1;
    bus.mode     = MODE_FIXED;
    bus.sel      = 2'd2;
    bus.in_valid = 4'b1111;
    set_data(2, 8'hA5);
    @(negedge clk); chk("fix_ready", bus.in_ready, 4'b0100);
    @(negedge clk);
    chk("fix_data", bus.out_data, 8'hA5);
    chk("fix_ch", bus.out_ch, 2);
    @(posedge clk); #1;
    bus.sel      = 2'd3;
    bus.in_valid = 4'b0111;
    @(negedge clk);
    chk("fix_no_ready", bus.in_ready, 4'b0000);
    chk("fix_hold_valid", bus.out_valid, 1);
    @(negedge clk); chk("fix_drop", bus.out_valid, 0);

    // Backpressure
    @(posedge clk); #1;
    bus.sel      = 2'd1;
    bus.in_valid = 4'b0010;
    set_data(1, 8'h3C);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    set_data(1, 8'h77);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_data", bus.out_data, 8'h3C);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_ready", bus.in_ready, 4'b0000);
      if (k < 2) @(posedge clk);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_bubble", bus.in_ready, 4'b0010);
    chk("bp_still_old", bus.out_data, 8'h3C);
    @(negedge clk); chk("bp_new_data", bus.out_data, 8'h77);

    // Mode switch leaves the RR pointer alone
    @(posedge clk); #1;
    bus.mode     = MODE_RR;
    bus.in_valid = 4'b0010;
    @(negedge clk); chk("ms_rr_ch1", bus.in_ready, 4'b0010);
    @(posedge clk); #1;
    bus.mode     = MODE_FIXED;
    bus.sel      = 2'd1;
    bus.in_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1 bus.mode = MODE_RR;
    @(negedge clk); chk("ms_rr_next", bus.in_ready, 4'b0100);
    @(negedge clk); chk("ms_out_ch", bus.out_ch, 2);

    // Reset in the middle of traffic
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", bus.out_valid, 0);
    chk("mrst_out_data", bus.out_data, 0);
    chk("mrst_out_ch", bus.out_ch, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("mrst_rr_first", bus.in_ready, 4'b0001);

`ifdef STREAM_MUX_CNT_EN
    @(posedge clk); #1;
    rst_n        = 1'b0;
    bus.in_valid = 4'b0000;
    bus.mode     = MODE_FIXED;
    bus.sel      = 2'd0;
    set_data(0, 8'h55);
    @(posedge clk); #1;
    rst_n        = 1'b1;
    bus.in_valid = 4'b0001;
    repeat (5) @(posedge clk);
    #1 bus.in_valid = 4'b0000;
    @(negedge clk);
    chk("cnt_ch0", grant_cnt[15:0], 5);
    chk("cnt_others", grant_cnt[63:16], 0);
    force u_dut.cnt_q = {16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
    #1 release u_dut.cnt_q;
    @(posedge clk); #1 bus.in_valid = 4'b0001;
    @(posedge clk); #1 bus.in_valid = 4'b0000;
    @(negedge clk); chk("cnt_sat", grant_cnt[15:0], 16'hFFFF);
`endif

    @(posedge clk); #1 bus.in_valid = 4'b0000;
    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
